// File: rtl/main_control_fsm_pkg.sv
// ---------------------------------------------------------------------------
// main_control_fsm_pkg
// Shared definitions for the multicycle main control FSM and the downstream
// ALU control stage: state encoding, opcode constants, ALU-op classes, mux
// select encodings and the bundled datapath-control struct.
// ---------------------------------------------------------------------------
package main_control_fsm_pkg;

    // Controller states
    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_MEMADR  = 4'd2,
        ST_MEMRD   = 4'd3,
        ST_MEMWB   = 4'd4,
        ST_MEMWR   = 4'd5,
        ST_EXEC    = 4'd6,
        ST_RTWB    = 4'd7,
        ST_BRANCH  = 4'd8,
        ST_JUMP    = 4'd9,
        ST_IMMEXEC = 4'd10,
        ST_IMMWB   = 4'd11
    } state_t;

    // Supported opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    // ALU-control classes consumed by the ALU control stage
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_SLT   = 2'b11;

    // ALU B operand select
    localparam logic [1:0] ALUB_REG    = 2'b00;
    localparam logic [1:0] ALUB_FOUR   = 2'b01;
    localparam logic [1:0] ALUB_SEXT   = 2'b10;
    localparam logic [1:0] ALUB_SHIFT  = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Bundle of all datapath controls
    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       memtoreg;
        logic       regwrite;
        logic       regdst;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsource;
        logic [1:0] aluop;
    } ctrl_t;

endpackage : main_control_fsm_pkg

// File: rtl/main_control_fsm_control_decode.sv
// ---------------------------------------------------------------------------
// control_decode
// Combinational Moore output decode for the main control FSM.
//   state     in  current controller state
//   opcode    in  instruction opcode (selects add/slt class in IMMEXEC)
//   mem_ready in  memory completion (gates irwrite/pcwrite in FETCH)
//   ctrl      out bundled datapath controls
// ---------------------------------------------------------------------------
module control_decode
    import main_control_fsm_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    // Per-state control decode; anything not set for a state stays 0
    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.memread  = 1'b1;
                ctrl.alusrcb  = ALUB_FOUR;
                ctrl.aluop    = ALUOP_ADD;
                ctrl.pcsource = PCSRC_ALU;
                // IR and PC only latch once the fetch completes
                ctrl.irwrite  = mem_ready;
                ctrl.pcwrite  = mem_ready;
            end
            ST_DECODE: begin
                ctrl.alusrcb = ALUB_SHIFT;
                ctrl.aluop   = ALUOP_ADD;
            end
            ST_MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = ALUB_SEXT;
                ctrl.aluop   = ALUOP_ADD;
            end
            ST_MEMRD: begin
                ctrl.memread = 1'b1;
                ctrl.iord    = 1'b1;
            end
            ST_MEMWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
            end
            ST_MEMWR: begin
                ctrl.memwrite = 1'b1;
                ctrl.iord     = 1'b1;
            end
            ST_EXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = ALUB_REG;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            ST_RTWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alusrca     = 1'b1;
                ctrl.alusrcb     = ALUB_REG;
                ctrl.aluop       = ALUOP_SUB;
                ctrl.pcwritecond = 1'b1;
                ctrl.pcsource    = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                ctrl.pcwrite  = 1'b1;
                ctrl.pcsource = PCSRC_JUMP;
            end
            ST_IMMEXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = ALUB_SEXT;
                if (opcode == OP_SLTI) begin
                    ctrl.aluop = ALUOP_SLT;
                end else begin
                    ctrl.aluop = ALUOP_ADD;
                end
            end
            ST_IMMWB: begin
                ctrl.regwrite = 1'b1;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule : control_decode

// File: rtl/main_control_fsm.sv
// ---------------------------------------------------------------------------
// main_control_fsm
// Multicycle main controller (lw, sw, R-type, beq, j, addi, slti).
//   clk, rst        clock; synchronous active-high reset
//   opcode          instruction[31:26], stable from DECODE to next FETCH
//   mem_ready       completion of the current memory access
//   pcwrite..aluop  datapath controls (Moore decode, forced 0 during rst)
//   illegal         one-cycle pulse after an unsupported opcode is decoded
//   instr_count     completed-instruction counter (wraps at 16 bits)
// ---------------------------------------------------------------------------
module main_control_fsm
    import main_control_fsm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic        pcwrite,
    output logic        pcwritecond,
    output logic        iord,
    output logic        memread,
    output logic        memwrite,
    output logic        irwrite,
    output logic        memtoreg,
    output logic        regwrite,
    output logic        regdst,
    output logic        alusrca,
    output logic [1:0]  alusrcb,
    output logic [1:0]  pcsource,
    output logic [1:0]  aluop,
    output logic        illegal,
    output logic [15:0] instr_count
);

    state_t      state_r;
    logic        illegal_r;
    logic [15:0] count_r;
    ctrl_t       ctrl_s;
    ctrl_t       ctrl_out_s;

    control_decode u_decode (
        .state     (state_r),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .ctrl      (ctrl_s)
    );

    // Reset overrides the FETCH decode so nothing strobes while held in reset
    assign ctrl_out_s = rst ? ctrl_t'(0) : ctrl_s;

    assign pcwrite     = ctrl_out_s.pcwrite;
    assign pcwritecond = ctrl_out_s.pcwritecond;
    assign iord        = ctrl_out_s.iord;
    assign memread     = ctrl_out_s.memread;
    assign memwrite    = ctrl_out_s.memwrite;
    assign irwrite     = ctrl_out_s.irwrite;
    assign memtoreg    = ctrl_out_s.memtoreg;
    assign regwrite    = ctrl_out_s.regwrite;
    assign regdst      = ctrl_out_s.regdst;
    assign alusrca     = ctrl_out_s.alusrca;
    assign alusrcb     = ctrl_out_s.alusrcb;
    assign pcsource    = ctrl_out_s.pcsource;
    assign aluop       = ctrl_out_s.aluop;
    assign illegal     = illegal_r;
    assign instr_count = count_r;

    // State register, illegal-opcode pulse and completed-instruction counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_FETCH;
            illegal_r <= 1'b0;
            count_r   <= 16'h0000;
        end else begin
            illegal_r <= 1'b0;
            case (state_r)
                ST_FETCH: begin
                    if (mem_ready) begin
                        state_r <= ST_DECODE;
                    end else begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW:     state_r <= ST_MEMADR;
                        OP_RTYPE:         state_r <= ST_EXEC;
                        OP_BEQ:           state_r <= ST_BRANCH;
                        OP_J:             state_r <= ST_JUMP;
                        OP_ADDI, OP_SLTI: state_r <= ST_IMMEXEC;
                        default: begin
                            // Unsupported: abandon the instruction uncounted
                            state_r   <= ST_FETCH;
                            illegal_r <= 1'b1;
                        end
                    endcase
                end
                ST_MEMADR: begin
                    if (opcode == OP_SW) begin
                        state_r <= ST_MEMWR;
                    end else begin
                        state_r <= ST_MEMRD;
                    end
                end
                ST_MEMRD: begin
                    if (mem_ready) begin
                        state_r <= ST_MEMWB;
                    end else begin
                        state_r <= ST_MEMRD;
                    end
                end
                ST_MEMWR: begin
                    if (mem_ready) begin
                        state_r <= ST_FETCH;
                        count_r <= count_r + 16'd1;
                    end else begin
                        state_r <= ST_MEMWR;
                    end
                end
                ST_EXEC: begin
                    state_r <= ST_RTWB;
                end
                ST_IMMEXEC: begin
                    state_r <= ST_IMMWB;
                end
                ST_MEMWB, ST_RTWB, ST_IMMWB, ST_BRANCH, ST_JUMP: begin
                    state_r <= ST_FETCH;
                    count_r <= count_r + 16'd1;
                end
                default: begin
                    state_r <= ST_FETCH;
                end
            endcase
        end
    end

endmodule : main_control_fsm

// File: tb/tb_main_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_main_control_fsm
// Directed per-cycle stimulus; each cycle's expected controls, counter and
// illegal flag are queued by the stimulus and checked by a separate monitor
// on the falling edge.
// Control vector order: pcwrite pcwritecond iord memread memwrite irwrite
// memtoreg regwrite regdst alusrca alusrcb[1:0] pcsource[1:0] aluop[1:0]
// ---------------------------------------------------------------------------
module tb_main_control_fsm;

    localparam logic [5:0] C_LW   = 6'b100011;
    localparam logic [5:0] C_SW   = 6'b101011;
    localparam logic [5:0] C_RT   = 6'b000000;
    localparam logic [5:0] C_BEQ  = 6'b000100;
    localparam logic [5:0] C_J    = 6'b000010;
    localparam logic [5:0] C_ADDI = 6'b001000;
    localparam logic [5:0] C_SLTI = 6'b001010;
    localparam logic [5:0] C_BAD  = 6'b111111;

    // Hand-derived control vectors per state
    localparam logic [15:0] V_RST   = 16'h0000;
    localparam logic [15:0] V_F1    = 16'h9410; // FETCH, mem_ready=1
    localparam logic [15:0] V_F0    = 16'h1010; // FETCH, mem_ready=0
    localparam logic [15:0] V_DEC   = 16'h0030;
    localparam logic [15:0] V_MADR  = 16'h0060;
    localparam logic [15:0] V_MRD   = 16'h3000;
    localparam logic [15:0] V_MWB   = 16'h0300;
    localparam logic [15:0] V_MWR   = 16'h2800;
    localparam logic [15:0] V_EXEC  = 16'h0042;
    localparam logic [15:0] V_RTWB  = 16'h0180;
    localparam logic [15:0] V_BR    = 16'h4045;
    localparam logic [15:0] V_JMP   = 16'h8008;
    localparam logic [15:0] V_ADDI  = 16'h0060;
    localparam logic [15:0] V_SLTI  = 16'h0063;
    localparam logic [15:0] V_IMMWB = 16'h0100;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic        memtoreg, regwrite, regdst, alusrca;
    logic [1:0]  alusrcb, pcsource, aluop;
    logic        illegal;
    logic [15:0] instr_count;

    always #5 clk = ~clk;

    main_control_fsm dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .pcwrite     (pcwrite),
        .pcwritecond (pcwritecond),
        .iord        (iord),
        .memread     (memread),
        .memwrite    (memwrite),
        .irwrite     (irwrite),
        .memtoreg    (memtoreg),
        .regwrite    (regwrite),
        .regdst      (regdst),
        .alusrca     (alusrca),
        .alusrcb     (alusrcb),
        .pcsource    (pcsource),
        .aluop       (aluop),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    logic [15:0] ctrl_v;
    assign ctrl_v = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
                     memtoreg, regwrite, regdst, alusrca, alusrcb, pcsource, aluop};

    typedef struct {
        logic [15:0] ctrl;
        logic [15:0] cnt;
        logic        ill;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Drive one cycle of inputs and queue what the DUT must show this cycle
    task automatic cyc(input logic [5:0] op, input logic mr, input logic r,
                       input logic [15:0] ec, input logic [15:0] cnt,
                       input logic il, input string tag);
        exp_t e;
        opcode    = op;
        mem_ready = mr;
        rst       = r;
        e.ctrl = ec;
        e.cnt  = cnt;
        e.ill  = il;
        e.tag  = tag;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop and compare whenever an expectation is pending
    always @(negedge clk) begin : mon
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (ctrl_v !== e.ctrl) begin
                bad++;
                $display("FAIL %s ctrl got=%h want=%h", e.tag, ctrl_v, e.ctrl);
            end
            total++;
            if (instr_count !== e.cnt) begin
                bad++;
                $display("FAIL %s instr_count got=%h want=%h", e.tag, instr_count, e.cnt);
            end
            total++;
            if (illegal !== e.ill) begin
                bad++;
                $display("FAIL %s illegal got=%b want=%b", e.tag, illegal, e.ill);
            end
        end
    end

    initial begin
        rst = 1'b1; opcode = 6'b000000; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        cyc(C_LW, 1'b1, 1'b1, V_RST, 16'h0000, 1'b0, "reset");

        // lw, mem_ready=1: 5 cycles
        cyc(C_LW, 1'b1, 1'b0, V_F1,   16'h0000, 1'b0, "lw_fetch");
        cyc(C_LW, 1'b1, 1'b0, V_DEC,  16'h0000, 1'b0, "lw_decode");
        cyc(C_LW, 1'b1, 1'b0, V_MADR, 16'h0000, 1'b0, "lw_memadr");
        cyc(C_LW, 1'b1, 1'b0, V_MRD,  16'h0000, 1'b0, "lw_memrd");
        cyc(C_LW, 1'b1, 1'b0, V_MWB,  16'h0000, 1'b0, "lw_memwb");

        // fetch stall, then sw with 3 wait cycles in MEMWR
        cyc(C_SW, 1'b0, 1'b0, V_F0,   16'h0001, 1'b0, "fetch_stall");
        cyc(C_SW, 1'b1, 1'b0, V_F1,   16'h0001, 1'b0, "sw_fetch");
        cyc(C_SW, 1'b0, 1'b0, V_DEC,  16'h0001, 1'b0, "sw_decode_mr0");
        cyc(C_SW, 1'b0, 1'b0, V_MADR, 16'h0001, 1'b0, "sw_memadr_mr0");
        for (int i = 0; i < 3; i++) begin
            cyc(C_SW, 1'b0, 1'b0, V_MWR, 16'h0001, 1'b0, "sw_wait");
        end
        cyc(C_SW, 1'b1, 1'b0, V_MWR,  16'h0001, 1'b0, "sw_done");

        // R-type
        cyc(C_RT, 1'b1, 1'b0, V_F1,   16'h0002, 1'b0, "rt_fetch");
        cyc(C_RT, 1'b1, 1'b0, V_DEC,  16'h0002, 1'b0, "rt_decode");
        cyc(C_RT, 1'b1, 1'b0, V_EXEC, 16'h0002, 1'b0, "rt_exec");
        cyc(C_RT, 1'b1, 1'b0, V_RTWB, 16'h0002, 1'b0, "rt_wb");

        // slti
        cyc(C_SLTI, 1'b1, 1'b0, V_F1,    16'h0003, 1'b0, "slti_fetch");
        cyc(C_SLTI, 1'b1, 1'b0, V_DEC,   16'h0003, 1'b0, "slti_decode");
        cyc(C_SLTI, 1'b1, 1'b0, V_SLTI,  16'h0003, 1'b0, "slti_exec");
        cyc(C_SLTI, 1'b1, 1'b0, V_IMMWB, 16'h0003, 1'b0, "slti_wb");

        // addi
        cyc(C_ADDI, 1'b1, 1'b0, V_F1,    16'h0004, 1'b0, "addi_fetch");
        cyc(C_ADDI, 1'b1, 1'b0, V_DEC,   16'h0004, 1'b0, "addi_decode");
        cyc(C_ADDI, 1'b1, 1'b0, V_ADDI,  16'h0004, 1'b0, "addi_exec");
        cyc(C_ADDI, 1'b1, 1'b0, V_IMMWB, 16'h0004, 1'b0, "addi_wb");

        // unsupported opcode: back to FETCH, one-cycle illegal, count unchanged
        cyc(C_BAD, 1'b1, 1'b0, V_F1,  16'h0005, 1'b0, "bad_fetch");
        cyc(C_BAD, 1'b1, 1'b0, V_DEC, 16'h0005, 1'b0, "bad_decode");
        cyc(C_LW,  1'b1, 1'b0, V_F1,  16'h0005, 1'b1, "illegal_pulse");
        cyc(C_LW,  1'b1, 1'b0, V_DEC, 16'h0005, 1'b0, "illegal_clear");

        // reset in the middle of lw (MEMRD)
        cyc(C_LW, 1'b1, 1'b0, V_MADR, 16'h0005, 1'b0, "lw2_memadr");
        cyc(C_LW, 1'b1, 1'b1, V_RST,  16'h0005, 1'b0, "rst_in_memrd");
        cyc(C_LW, 1'b1, 1'b1, V_RST,  16'h0000, 1'b0, "rst_hold");
        cyc(C_J,  1'b1, 1'b0, V_F1,   16'h0000, 1'b0, "post_rst_fetch");

        // two jumps
        cyc(C_J, 1'b1, 1'b0, V_DEC, 16'h0000, 1'b0, "j0_decode");
        cyc(C_J, 1'b1, 1'b0, V_JMP, 16'h0000, 1'b0, "j0_jump");
        cyc(C_J, 1'b1, 1'b0, V_F1,  16'h0001, 1'b0, "j1_fetch");
        cyc(C_J, 1'b1, 1'b0, V_DEC, 16'h0001, 1'b0, "j1_decode");
        cyc(C_J, 1'b1, 1'b0, V_JMP, 16'h0001, 1'b0, "j1_jump");

        // preload the counter near its wrap point while stalled in FETCH
        force dut.count_r = 16'hFFFC;
        cyc(C_J, 1'b0, 1'b0, V_F0, 16'hFFFC, 1'b0, "preload");
        release dut.count_r;
        for (int k = 0; k < 3; k++) begin
            cyc(C_J, 1'b1, 1'b0, V_F1,  16'hFFFC + 16'(k), 1'b0, "jw_fetch");
            cyc(C_J, 1'b1, 1'b0, V_DEC, 16'hFFFC + 16'(k), 1'b0, "jw_decode");
            cyc(C_J, 1'b1, 1'b0, V_JMP, 16'hFFFC + 16'(k), 1'b0, "jw_jump");
        end

        // beq completes the wrap to 0x0000
        cyc(C_BEQ, 1'b1, 1'b0, V_F1,  16'hFFFF, 1'b0, "beq_fetch");
        cyc(C_BEQ, 1'b1, 1'b0, V_DEC, 16'hFFFF, 1'b0, "beq_decode");
        cyc(C_BEQ, 1'b1, 1'b0, V_BR,  16'hFFFF, 1'b0, "beq_branch");
        cyc(C_BEQ, 1'b0, 1'b0, V_F0,  16'h0000, 1'b0, "count_wrap");

        // drain the scoreboard within a bounded number of cycles
        for (int w = 0; w < 20 && q.size() > 0; w++) begin
            @(negedge clk);
        end
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain pending got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_main_control_fsm
